// File: rtl/arb_pkg.sv
// rtl/arb_pkg.sv - shared types, constants and round-robin pick for rr_dec_arbiter
package arb_pkg;

  localparam int NREQ = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    GAP  = 2'd2
  } arb_state_e;

  // Nearest requester after `last`, wrapping; `last` itself has lowest priority.
  function automatic logic [1:0] rr_pick(input logic [NREQ-1:0] req,
                                         input logic [1:0]      last);
    logic [1:0] idx;
    rr_pick = last;
    for (int i = NREQ; i >= 1; i--) begin
      idx = last + 2'(i);
      if (req[idx]) rr_pick = idx;
    end
  endfunction

endpackage

// File: rtl/dec2to4_pol.sv
// rtl/dec2to4_pol.sv - 2-to-4 one-hot decoder with enable and output polarity
module dec2to4_pol (
  input  logic [1:0] idx_i,
  input  logic       en_i,
  input  logic       pol_i,
  output logic [3:0] dec_o
);

  assign dec_o = (en_i ? (4'b0001 << idx_i) : 4'b0000) ^ {4{pol_i}};

endmodule

// File: rtl/rr_dec_arbiter.sv
// rtl/rr_dec_arbiter.sv - 4-way round-robin arbiter with hold timeout and decoded grant
module rr_dec_arbiter
  import arb_pkg::*;
#(
  parameter int MAX_HOLD = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NREQ-1:0] req,
  input  logic [NREQ-1:0] done,
  input  logic            inv,
  output logic [NREQ-1:0] gnt,
  output logic [1:0]      gnt_idx,
  output logic            busy,
  output logic            timeout
);

  localparam int CW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
  localparam logic [CW-1:0] HOLD_LAST = CW'((MAX_HOLD > 0) ? MAX_HOLD - 1 : 0);
  localparam logic [CW-1:0] CNT_MAX   = '1;

  arb_state_e    state_q, state_d;
  logic [1:0]    gnt_idx_q, gnt_idx_d;
  logic [1:0]    last_q, last_d;
  logic [CW-1:0] hold_cnt_q, hold_cnt_d;
  logic          timeout_q, timeout_d;
  logic [1:0]    winner;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      gnt_idx_q  <= 2'd0;
      last_q     <= 2'd3;
      hold_cnt_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      gnt_idx_q  <= gnt_idx_d;
      last_q     <= last_d;
      hold_cnt_q <= hold_cnt_d;
      timeout_q  <= timeout_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    gnt_idx_d  = gnt_idx_q;
    last_d     = last_q;
    hold_cnt_d = hold_cnt_q;
    timeout_d  = 1'b0;
    winner     = rr_pick(req, last_q);
    unique case (state_q)
      IDLE, GAP: begin
        if (|req) begin
          state_d    = BUSY;
          gnt_idx_d  = winner;
          last_d     = winner;
          hold_cnt_d = '0;
        end else begin
          state_d = IDLE;
        end
      end
      BUSY: begin
        // Saturate rather than wrap so a disabled timeout never aliases.
        if (hold_cnt_q != CNT_MAX) hold_cnt_d = hold_cnt_q + CW'(1);
        if (done[gnt_idx_q]) begin
          state_d = GAP;
        end else if (MAX_HOLD != 0 && hold_cnt_q == HOLD_LAST) begin
          state_d   = GAP;
          timeout_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy    = (state_q == BUSY);
  assign gnt_idx = gnt_idx_q;
  assign timeout = timeout_q;

  dec2to4_pol u_gnt_dec (
    .idx_i (gnt_idx_q),
    .en_i  (busy),
    .pol_i (inv),
    .dec_o (gnt)
  );

endmodule

// File: tb/tb_rr_dec_arbiter.sv
// tb/tb_rr_dec_arbiter.sv - self-checking bench for rr_dec_arbiter
module tb_rr_dec_arbiter;

  localparam int MH = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] req = 4'b0, done = 4'b0;
  logic       inv = 1'b0;
  logic [3:0] gnt;
  logic [1:0] gnt_idx;
  logic       busy, timeout;

  int total = 0;
  int bad = 0;

  // reference: who holds the resource, for how long, and who was served last
  bit m_own;
  int m_idx, m_last, m_age;
  bit m_to;

  rr_dec_arbiter #(.MAX_HOLD(MH)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .done(done), .inv(inv),
    .gnt(gnt), .gnt_idx(gnt_idx), .busy(busy), .timeout(timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  function automatic int pick(input logic [3:0] r, input int last);
    for (int k = 1; k <= 4; k++)
      if (r[(last + k) % 4]) return (last + k) % 4;
    return last;
  endfunction

  task automatic model_edge();
    if (!rst_n) begin
      m_own = 0; m_idx = 0; m_last = 3; m_age = 0; m_to = 0;
    end else begin
      m_to = 0;
      if (m_own) begin
        if (done[m_idx]) m_own = 0;
        else if (m_age == MH - 1) begin m_own = 0; m_to = 1; end
        else m_age++;
      end else if (req != 4'b0) begin
        m_idx = pick(req, m_last); m_last = m_idx; m_own = 1; m_age = 0;
      end
    end
  endtask

  task automatic step(input string tag);
    logic [3:0] eg;
    @(posedge clk);
    model_edge();
    #1;
    eg = (m_own ? (4'b0001 << m_idx) : 4'b0000) ^ {4{inv}};
    chk({tag, ".gnt"}, gnt, eg);
    chk({tag, ".idx"}, {2'b0, gnt_idx}, 4'(m_idx));
    chk({tag, ".busy"}, {3'b0, busy}, {3'b0, m_own});
    chk({tag, ".to"}, {3'b0, timeout}, {3'b0, m_to});
  endtask

  logic [3:0] inv_seq [4];
  int cnt;

  initial begin
    inv_seq[0] = 4'b1110; inv_seq[1] = 4'b1101; inv_seq[2] = 4'b1011; inv_seq[3] = 4'b0111;

    // reset
    step("rst0"); step("rst1");
    rst_n = 1'b1;
    step("rst_rel");
    chk("rst_gnt", gnt, 4'b0000);
    inv = 1'b1; #1;
    chk("rst_gnt_inv", gnt, 4'b1111);
    inv = 1'b0;

    // single request
    req = 4'b0100;
    step("single_g");
    chk("single_gnt", gnt, 4'b0100);
    chk("single_idx", {2'b0, gnt_idx}, 4'd2);
    done = 4'b0100; req = 4'b0000;
    step("single_gap");
    chk("single_gap_gnt", gnt, 4'b0000);
    done = 4'b0000;
    step("single_idle");

    // rotation with inverted polarity, from a fresh reset
    rst_n = 1'b0; step("rot_rst"); rst_n = 1'b1;
    inv = 1'b1; req = 4'b1111;
    for (int k = 0; k < 4; k++) begin
      step("rot_g");
      chk("rot_inv_gnt", gnt, inv_seq[k]);
      step("rot_h");
      done = 4'b0001 << m_idx;
      if (k == 3) req = 4'b0000;
      step("rot_gap");
      chk("rot_gap_busy", {3'b0, busy}, 4'b0);
      done = 4'b0000;
    end
    step("rot_idle");
    inv = 1'b0; req = 4'b1111;
    step("rot0");
    chk("rot_wrap_idx", {2'b0, gnt_idx}, 4'd0);
    done = 4'b0001; req = 4'b0000; step("rot0_rel"); done = 4'b0000; step("rot0_idle");

    // timeout: grant lasts exactly MH cycles, then a one-cycle pulse and regrant
    req = 4'b0010;
    cnt = 0;
    step("to_g");
    while (busy && cnt < 20) begin cnt++; step("to_h"); end
    chk("to_len", 4'(cnt), 4'(MH));
    chk("to_pulse", {3'b0, timeout}, 4'b0001);
    chk("to_gap_gnt", gnt, 4'b0000);
    step("to_regrant");
    chk("to_regrant_busy", {3'b0, busy}, 4'b0001);

    // non-owner done ignored
    done = 4'b0001;
    step("nonown0");
    step("nonown1");
    chk("nonown_busy", {3'b0, busy}, 4'b0001);
    done = 4'b0010; req = 4'b0000; step("nonown_rel"); done = 4'b0000; step("nonown_idle");

    // done on the timeout edge: release without pulse
    req = 4'b0010;
    step("edge_g"); step("edge_1"); step("edge_2"); step("edge_3");
    done = 4'b0010;
    step("edge_rel");
    chk("edge_no_to", {3'b0, timeout}, 4'b0000);
    chk("edge_busy", {3'b0, busy}, 4'b0000);
    done = 4'b0000; req = 4'b0000; step("edge_idle");

    // reset mid-grant, then requester 0 must win
    req = 4'b1000;
    step("mrst_g");
    rst_n = 1'b0; req = 4'b0000;
    step("mrst");
    chk("mrst_busy", {3'b0, busy}, 4'b0000);
    chk("mrst_gnt", gnt, 4'b0000);
    rst_n = 1'b1; req = 4'b1001;
    step("mrst_next");
    chk("mrst_next_idx", {2'b0, gnt_idx}, 4'd0);

    // random traffic against the reference model
    for (int i = 0; i < 400; i++) begin
      req  = 4'($urandom);
      done = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000;
      rst_n = ($urandom_range(0, 60) != 0);
      if (!m_own && $urandom_range(0, 7) == 0) inv = ~inv;
      step("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
